seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-segment multi-digit 7-segment display. It holds a frame-coherent copy of NUM_DIGITS hex nibbles and cycles one digit at a time through a single hex-to-7-segment decoder, driving one-hot digit enables. A blanking gap between digits prevents ghosting, and optional leading-zero suppression is applied. It sits between the numeric datapath (counters, converters) and the board display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 39 +++
 rtl/seg_scan_ctrl_hex_to_7seg.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared display definitions for the 7-segment scan path.
//   - Segment bit order: seg[6:0] = {a,b,c,d,e,f,g}, MSB = a.
//   - Output polarity constants (all active high on this board).
//   - Slot state type used by the scan controller.
//   - idx_width(): index width for a counter of n positions (clog2, min 1).
// ---------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

    localparam int SEG_W = 7;

    // Bit positions inside seg[6:0].
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Level that lights a segment, digit anode or decimal point.
    localparam logic SEG_ON = 1'b1;
    localparam logic AN_ON  = 1'b1;
    localparam logic DP_ON  = 1'b1;

    // Segment pattern that leaves every segment dark.
    localparam logic [SEG_W-1:0] SEG_DARK = {SEG_W{~SEG_ON}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// ---------------------------------------------------------------------------
// hex_to_7seg
// Combinational hex nibble to 7-segment decoder.
//   nibble : in  [3:0]  hex digit 0..F
//   seg    : out [6:0]  {a,b,c,d,e,f,g}, polarity from SEG_ON
// Lower-case b and d are used so they are distinguishable from 8 and 0.
// ---------------------------------------------------------------------------
module hex_to_7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    logic [SEG_W-1:0] lit;   // 1 = segment lit, independent of pin polarity

    always_comb begin
        case (nibble)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            default: lit = 7'b1000111;   // F
        endcase
    end

    assign seg = (SEG_ON == 1'b1) ? lit : ~lit;

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Each digit owns a slot of CLK_DIV cycles; the first BLANK_CYCLES of a slot
// are dark to avoid ghosting. The displayed value only changes at a frame
// start (cnt=0, idx=0), so a frame never mixes old and new digits.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        1 = scan; 0 = outputs dark, scan parked at digit 0
//   load          single-cycle request to take value/dp_in
//   value         NUM_DIGITS hex nibbles, nibble 0 = least significant digit
//   dp_in         per-digit decimal point request
//   lz_blank_en   suppress leading zeros (digit 0 always shown)
//   load_ack      one-cycle pulse when a loaded value becomes visible
//   frame_start   one-cycle pulse on the first output cycle of digit-0 slot
//   an            one-hot digit enable
//   seg           {a,b,c,d,e,f,g}
//   dp            decimal point
// All display outputs are registered: one cycle behind (cnt, idx).
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(CLK_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] idx, idx_d;
    slot_state_e      state;

    // Displayed and pending values
    logic [VAL_W-1:0]      disp_reg, pend_val, disp_eff;
    logic [NUM_DIGITS-1:0] dp_reg,   pend_dp,  dp_eff;
    logic                  pend_valid;

    // Frame-start transfer decisions
    logic frame_slot, commit_load, commit_pend;

    // Digit selection and leading-zero mask
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    logic [SEG_W-1:0]      dec_seg;

    // Registered outputs and their next values
    logic [NUM_DIGITS-1:0] an_d;
    logic [SEG_W-1:0]      seg_d;
    logic                  dp_d;

    // -----------------------------------------------------------------------
    // Slot counter / digit index next state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt;
        idx_d = idx;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    // Slot phase is a pure function of cnt; with no gap the slot is always lit.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_gap
            assign state = ST_ON;
        end else begin : g_gap
            assign state = (cnt < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_ON;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Frame-coherent load. The value chosen here is what disp_reg becomes at
    // this edge; using it for the output path as well means the first lit
    // cycle of a frame already shows the new value even without a gap.
    // -----------------------------------------------------------------------
    assign frame_slot  = enable && (cnt == '0) && (idx == '0);
    assign commit_load = frame_slot && load;
    assign commit_pend = frame_slot && pend_valid && !load;

    always_comb begin
        disp_eff = disp_reg;
        dp_eff   = dp_reg;
        if (commit_load) begin
            disp_eff = value;
            dp_eff   = dp_in;
        end else if (commit_pend) begin
            disp_eff = pend_val;
            dp_eff   = pend_dp;
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero mask and current digit selection
    // -----------------------------------------------------------------------
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        // Walk from the most significant digit down; a digit is blanked while
        // it and everything above it is zero. Digit 0 is never touched.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_eff[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_blank_en && zero_above;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_eff[4*i +: 4];
                cur_dp    = dp_eff[i];
                cur_blank = lz_mask[i];
            end
        end
    end

    hex_to_7seg u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // -----------------------------------------------------------------------
    // Output next values
    // -----------------------------------------------------------------------
    always_comb begin
        an_d  = {NUM_DIGITS{~AN_ON}};
        seg_d = SEG_DARK;
        dp_d  = ~DP_ON;
        if (enable && (state == ST_ON)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx == IDX_W'(i)) ? AN_ON : ~AN_ON;
            end
            seg_d = cur_blank ? SEG_DARK : dec_seg;
            dp_d  = cur_dp ? DP_ON : ~DP_ON;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            disp_reg    <= '0;
            dp_reg      <= '0;
            pend_valid  <= 1'b0;
            an          <= {NUM_DIGITS{~AN_ON}};
            seg         <= SEG_DARK;
            dp          <= ~DP_ON;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            idx         <= idx_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            load_ack    <= commit_load || commit_pend;
            frame_start <= frame_slot;

            if (commit_load || commit_pend) begin
                disp_reg <= disp_eff;
                dp_reg   <= dp_eff;
            end

            if (frame_slot) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // NOTE: the pending data register has no reset; it is only ever read
    // when pend_valid is set, and pend_valid is reset.
    always_ff @(posedge clk) begin
        if (load && !frame_slot) begin
            pend_val <= value;
            pend_dp  <= dp_in;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed plus randomized stimulus for seg_scan_ctrl (4 digits, 8-cycle
// slots, 2 dark cycles). The reference model tracks only the number of
// enabled cycles since the scan last restarted and derives slot, phase and
// frame boundaries from it arithmetically, plus the shown/pending values.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int CD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = CD * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          lz_blank_en = 1'b0;
    logic          load_ack;
    logic          frame_start;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          t = 0;          // enabled cycles since scan restart
    logic [15:0] shown = '0;
    logic [3:0]  shown_dp = '0;
    logic [15:0] pend_v = '0;
    logic [3:0]  pend_dp = '0;
    bit          pend = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expv, t);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, ".an"},  32'(an),          32'h0);
        check({tag, ".seg"}, 32'(seg),         32'h0);
        check({tag, ".dp"},  32'(dp),          32'h0);
        check({tag, ".ack"}, 32'(load_ack),    32'h0);
        check({tag, ".fs"},  32'(frame_start), 32'h0);
    endtask

    // One clock: predict the outputs produced by this edge from the current
    // inputs and model state, advance the model, then compare after the edge.
    task automatic tick();
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fs, e_ack;
        bit          fs;
        logic [15:0] eff;
        logic [3:0]  eff_dp;
        int          slot, off;
        e_an = '0; e_seg = '0; e_dp = 1'b0; e_fs = 1'b0; e_ack = 1'b0;
        if (enable) begin
            fs     = (t % FRAME) == 0;
            eff    = shown;
            eff_dp = shown_dp;
            if (fs && load) begin
                eff = value; eff_dp = dp_in;
            end else if (fs && pend) begin
                eff = pend_v; eff_dp = pend_dp;
            end
            slot = (t / CD) % ND;
            off  = t % CD;
            if (off >= BC) begin
                e_an = 4'(1 << slot);
                e_dp = eff_dp[slot];
                if (lz_blank_en && slot > 0 && (eff >> (4 * slot)) == 16'h0)
                    e_seg = 7'b0;
                else
                    e_seg = hex_seg(4'(eff >> (4 * slot)));
            end
            e_fs  = fs;
            e_ack = fs && (load || pend);
            if (fs) begin
                shown = eff; shown_dp = eff_dp; pend = 1'b0;
            end else if (load) begin
                pend_v = value; pend_dp = dp_in; pend = 1'b1;
            end
            t++;
        end else begin
            if (load) begin
                pend_v = value; pend_dp = dp_in; pend = 1'b1;
            end
            t = 0;
        end
        @(posedge clk);
        #1;
        check("an",          32'(an),          32'(e_an));
        check("seg",         32'(seg),         32'(e_seg));
        check("dp",          32'(dp),          32'(e_dp));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("load_ack",    32'(load_ack),    32'(e_ack));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Advance until the model sits at frame offset k (bounded by one frame).
    task automatic run_to(input int k);
        for (int g = 0; g < FRAME && (t % FRAME) != k; g++) tick();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset");

        // Scan order with load coincident with the first frame start
        rst_n = 1'b1;
        enable = 1'b1;
        pulse_load(16'h1234, 4'b0000);
        run(2 * FRAME);

        // Frame coherence: load mid-frame during digit-2 slot
        run_to(2 * CD + 4);
        pulse_load(16'hABCD, 4'b0000);
        run(FRAME + 16);

        // Last wins within a frame, then load exactly at a frame start
        run_to(5);
        pulse_load(16'h1111, 4'b0000);
        run(6);
        pulse_load(16'h2222, 4'b0000);
        run_to(0);
        run(FRAME);
        pulse_load(16'h5A5A, 4'b0011);
        run(FRAME);

        // Leading-zero suppression on and off
        lz_blank_en = 1'b1;
        run_to(9);
        pulse_load(16'h0050, 4'b0000);
        run_to(0);
        run(FRAME);
        lz_blank_en = 1'b0;
        run(FRAME);
        lz_blank_en = 1'b1;
        pulse_load(16'h0000, 4'b0000);
        run_to(0);
        run(FRAME);

        // Enable gating mid-slot, dp on digit 2, restart at digit 0
        run_to(13);
        enable = 1'b0;
        run(3);
        value = 16'h8421; dp_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        enable = 1'b1;
        run(2 * FRAME);

        // Randomized traffic
        for (int r = 0; r < 400; r++) begin
            load        = ($urandom_range(0, 11) == 0);
            value       = 16'($urandom);
            dp_in       = 4'($urandom);
            enable      = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 29) == 0) lz_blank_en = ~lz_blank_en;
            tick();
        end
        load = 1'b0;
        enable = 1'b1;
        run(FRAME);

        // Async reset between edges, then display shows zeros until a load
        lz_blank_en = 1'b0;
        pulse_load(16'h9876, 4'b1111);
        run_to(20);
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_reset");
        t = 0; shown = '0; shown_dp = '0; pend = 1'b0;
        @(posedge clk);
        #1;
        check_dark("in_reset");
        rst_n = 1'b1;
        run(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
